// File: rtl/lr35902_dbg_host.sv
`default_nettype none
// lr35902_dbg_host: serialises debugger commands onto the target rx line and collects the step register dump.
// Optional macro DBG_HOST_TIMEOUT_EN adds a step-response timeout (STEP_TIMEOUT bit times).
module lr35902_dbg_host #(
  parameter int DUMP_LEN     = 24,
  parameter int STEP_TIMEOUT = 4096
) (
  input  logic       uart_clk,
  input  logic       reset,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       busy,
  output logic       tx,
  input  logic       rx,
  input  logic       cts,
  output logic [7:0] dump_data,
  output logic [4:0] dump_idx,
  output logic       dump_valid,
  output logic       dump_done,
  output logic       err
);
  localparam logic [4:0] LAST_IDX = 5'(DUMP_LEN - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_GUARD, TX_RESP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t  tx_state, tx_next;
  rx_state_t  rx_state, rx_next;

  logic       rx_meta, rx_s, rx_prev, cts_meta, cts_s;
  logic [3:0] tx_cnt, rx_cnt, cts_low;
  logic [2:0] tx_bit, rx_bit;
  logic [7:0] tx_shift, rx_shift;
  logic       tx_stop, is_step, rx_brk_wait;
  logic [4:0] resp_cnt;
  logic [7:0] cmd_byte;
  logic       cmd_rsvd, accept, tx_tick, rx_tick;
  logic       byte_good, byte_bad, start_seen, timeout;

  always_ff @(posedge uart_clk) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      cts_meta <= 1'b0;
      cts_s    <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      cts_meta <= cts;
      cts_s    <= cts_meta;
    end
  end

  always_comb begin
    cmd_byte = 8'h00;
    cmd_rsvd = 1'b0;
    case (cmd)
      3'd0:    cmd_byte = 8'h00;
      3'd1:    cmd_byte = 8'h63;
      3'd2:    cmd_byte = 8'h69;
      3'd3:    cmd_byte = 8'h49;
      3'd4:    cmd_byte = 8'h64;
      3'd5:    cmd_byte = 8'h73;
      default: cmd_rsvd = 1'b1;
    endcase
  end

  assign cmd_ready = !busy && reset;
  assign accept    = cmd_valid && cmd_ready && (tx_state == TX_IDLE);
  assign tx_tick   = (tx_cnt == 4'd11);
  assign rx_tick   = (rx_cnt == 4'd11);

  // ---------------- TX FSM ----------------
  always_ff @(posedge uart_clk) begin
    if (!reset) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (accept && !cmd_rsvd) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_GUARD;
      TX_GUARD: if (cts_low == 4'd12) tx_next = is_step ? TX_RESP : TX_IDLE;
      TX_RESP:  if (byte_bad || timeout || (byte_good && resp_cnt == LAST_IDX)) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // tx is registered from the current state, so the start bit appears one edge after accept
  always_ff @(posedge uart_clk) begin
    if (!reset) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_cnt   <= 4'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      tx_stop  <= 1'b1;
      is_step  <= 1'b0;
      cts_low  <= 4'd0;
    end else begin
      busy <= (tx_state != TX_IDLE);
      case (tx_state)
        TX_START: tx <= 1'b0;
        TX_DATA:  tx <= tx_shift[tx_bit];
        TX_STOP:  tx <= tx_stop;
        default:  tx <= 1'b1;
      endcase
      if (accept && !cmd_rsvd) begin
        tx_shift <= cmd_byte;
        tx_stop  <= (cmd != 3'd0);
        is_step  <= (cmd == 3'd5);
        tx_cnt   <= 4'd0;
        tx_bit   <= 3'd0;
      end else if (tx_state == TX_START || tx_state == TX_DATA || tx_state == TX_STOP) begin
        tx_cnt <= tx_tick ? 4'd0 : tx_cnt + 4'd1;
        if (tx_state == TX_DATA && tx_tick) tx_bit <= tx_bit + 3'd1;
      end
      // consecutive low-cycle count of cts, saturating at one bit time
      if (cts_s)                 cts_low <= 4'd0;
      else if (cts_low != 4'd12) cts_low <= cts_low + 4'd1;
    end
  end

  // ---------------- RX FSM ----------------
  always_ff @(posedge uart_clk) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next    = rx_state;
    byte_good  = 1'b0;
    byte_bad   = 1'b0;
    start_seen = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_s) begin
        rx_next    = RX_START;
        start_seen = 1'b1;
      end
      RX_START: if (rx_cnt == 4'd4) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (rx_brk_wait) begin
          if (rx_s) rx_next = RX_IDLE;
        end else if (rx_tick) begin
          if (rx_s) begin
            byte_good = 1'b1;
            rx_next   = RX_IDLE;
          end else begin
            byte_bad = 1'b1;
          end
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (!reset) begin
      rx_cnt      <= 4'd0;
      rx_bit      <= 3'd0;
      rx_shift    <= 8'h00;
      rx_brk_wait <= 1'b0;
    end else begin
      rx_cnt <= (rx_next != rx_state || rx_tick) ? 4'd0 : rx_cnt + 4'd1;
      if (rx_state == RX_START) rx_bit <= 3'd0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
      // after a bad stop bit, hold in RX_STOP until the line idles so the break is not a new start
      if (byte_bad)                    rx_brk_wait <= 1'b1;
      else if (rx_next != RX_STOP)     rx_brk_wait <= 1'b0;
    end
  end

`ifdef DBG_HOST_TIMEOUT_EN
  localparam int TO_CLKS = STEP_TIMEOUT * 12;
  localparam int TO_W    = $clog2(TO_CLKS + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_armed;

  always_ff @(posedge uart_clk) begin
    if (!reset || tx_state != TX_RESP) begin
      to_cnt   <= '0;
      to_armed <= 1'b1;
    end else if (start_seen) begin
      to_armed <= 1'b0;
    end else if (to_armed) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign timeout = (tx_state == TX_RESP) && to_armed && !start_seen && (to_cnt == TO_W'(TO_CLKS - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge uart_clk) begin
    if (!reset) begin
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      err        <= 1'b0;
      dump_idx   <= 5'd0;
      dump_data  <= 8'h00;
      resp_cnt   <= 5'd0;
    end else begin
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      err        <= 1'b0;
      if (tx_state == TX_GUARD && tx_next == TX_RESP) begin
        resp_cnt <= 5'd0;
        dump_idx <= 5'd0;
      end else if (tx_state == TX_RESP) begin
        if (byte_good) begin
          dump_valid <= 1'b1;
          dump_data  <= rx_shift;
          dump_idx   <= resp_cnt;
          dump_done  <= (resp_cnt == LAST_IDX);
          resp_cnt   <= resp_cnt + 5'd1;
        end
        if (byte_bad || timeout) err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lr35902_dbg_host.sv
`default_nettype none
// Bench for lr35902_dbg_host: random commands and dumps checked against a frame-level line model.
module tb_lr35902_dbg_host;
  localparam int DUMP_LEN = 24;
  localparam int STEP_TO  = 64;
  localparam int RX_LAT   = 2 + 6 + 9 * 12;

  logic       uart_clk = 1'b0;
  logic       reset, cmd_valid, rx, cts;
  logic [2:0] cmd;
  logic       cmd_ready, busy, tx, dump_valid, dump_done, err;
  logic [7:0] dump_data;
  logic [4:0] dump_idx;

  lr35902_dbg_host #(.DUMP_LEN(DUMP_LEN), .STEP_TIMEOUT(STEP_TO)) dut (
    .uart_clk(uart_clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .busy(busy), .tx(tx), .rx(rx), .cts(cts),
    .dump_data(dump_data), .dump_idx(dump_idx), .dump_valid(dump_valid),
    .dump_done(dump_done), .err(err)
  );

  always #5 uart_clk = ~uart_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge uart_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // observed dump strobes
  typedef struct {logic [7:0] data; logic [4:0] idx; logic done; int t;} dump_ev_t;
  dump_ev_t got_q[$];
  dump_ev_t ev;
  int err_cnt = 0;
  int done_alone = 0;
  int start_q[$];

  always @(posedge uart_clk) begin
    #1;
    if (dump_valid) begin
      ev.data = dump_data; ev.idx = dump_idx; ev.done = dump_done; ev.t = cyc;
      got_q.push_back(ev);
    end else if (dump_done) begin
      done_alone++;
    end
    if (err) err_cnt++;
  end

  function automatic logic [7:0] cmd_code(input logic [2:0] c);
    logic [7:0] tab [6];
    tab = '{8'h00, 8'h63, 8'h69, 8'h49, 8'h64, 8'h73};
    return tab[c];
  endfunction

  // expected line level at clock i (1..120) of a frame: start, 8 data LSB first, stop
  function automatic logic frame_bit(input logic [7:0] b, input logic stop_b, input int i);
    int k;
    k = (i - 1) / 12;
    if (k == 0) return 1'b0;
    if (k == 9) return stop_b;
    return b[k-1];
  endfunction

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(posedge uart_clk); #1; n++;
    end
    check("idle_reached", busy, 1'b0);
    check("ready_back", cmd_ready, 1'b1);
  endtask

  task automatic send_cmd(input logic [2:0] c, input bit use_cts, input int hold);
    logic [7:0] eb, rb;
    logic       es, rs;
    int         mism, lat, low_busy;
    eb = cmd_code(c);
    es = (c != 3'd0);
    mism = 0; rb = 8'h00; rs = 1'b0; low_busy = 0;
    @(negedge uart_clk);
    check("ready_pre", cmd_ready, 1'b1);
    cmd = c; cmd_valid = 1'b1;
    @(posedge uart_clk); #1;
    check("tx_at_accept", tx, 1'b1);
    check("busy_at_accept", busy, 1'b0);
    @(negedge uart_clk); cmd_valid = 1'b0;
    for (int i = 1; i <= 120; i++) begin
      @(posedge uart_clk); #1;
      if (i == 1) check("busy_rise", busy, 1'b1);
      if (tx !== frame_bit(eb, es, i)) mism++;
      if ((i - 1) % 12 == 5) begin
        if ((i - 1) / 12 == 9) rs = tx;
        else if ((i - 1) / 12 >= 1) rb[(i - 1) / 12 - 1] = tx;
      end
      if (use_cts && i == 60) cts = 1'b1;
    end
    check("tx_byte", rb, eb);
    check("tx_stop", rs, es);
    check("tx_wave_errs", mism, 0);
    @(posedge uart_clk); #1;
    check("tx_release", tx, 1'b1);
    if (use_cts) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge uart_clk); #1;
        if (!busy) low_busy++;
      end
      check("busy_held_by_cts", low_busy, 0);
      cts = 1'b0;
      lat = 0;
      while (busy && lat < 40) begin
        @(posedge uart_clk); #1; lat++;
      end
      check($sformatf("guard_lat=%0d", lat), (lat >= 14 && lat <= 16), 1'b1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_b);
    @(negedge uart_clk);
    rx = 1'b0;
    start_q.push_back(cyc);
    repeat (11) @(negedge uart_clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (12) @(negedge uart_clk);
    end
    rx = stop_b;
    repeat (12) @(negedge uart_clk);
    rx = 1'b1;
  endtask

  task automatic run_step(input int bad_at, input bit glitch, input bit seq);
    logic [7:0] bytes [DUMP_LEN];
    int         n_send, n_exp, e0, d0;
    for (int i = 0; i < DUMP_LEN; i++) bytes[i] = seq ? 8'(i) : 8'($urandom);
    n_send = (bad_at >= 0) ? bad_at + 1 : DUMP_LEN;
    n_exp  = (bad_at >= 0) ? bad_at : DUMP_LEN;
    send_cmd(3'd5, 1'b0, 0);
    got_q.delete(); start_q.delete();
    e0 = err_cnt; d0 = done_alone;
    if (glitch) begin
      @(negedge uart_clk); rx = 1'b0;
      repeat (2) @(negedge uart_clk); rx = 1'b1;
      repeat (20) @(negedge uart_clk);
    end
    @(posedge uart_clk); #1;
    check("resp_busy", busy, 1'b1);
    for (int i = 0; i < n_send; i++) begin
      send_byte(bytes[i], (i != bad_at));
      repeat ($urandom_range(0, 3)) @(negedge uart_clk);
    end
    wait_idle(200);
    repeat (3) @(posedge uart_clk);
    #1;
    check("dump_count", got_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < got_q.size(); i++) begin
      check($sformatf("dump_ev%0d", i), {got_q[i].idx, got_q[i].data, got_q[i].done},
            {5'(i), bytes[i], (i == DUMP_LEN - 1)});
      check($sformatf("dump_lat%0d", i), got_q[i].t - start_q[i], RX_LAT);
    end
    check("dump_err", err_cnt - e0, (bad_at >= 0) ? 1 : 0);
    check("done_alone", done_alone - d0, 0);
  endtask

  task automatic run_reserved(input logic [2:0] c);
    int lows, busys;
    lows = 0; busys = 0;
    @(negedge uart_clk);
    check("rsv_ready", cmd_ready, 1'b1);
    cmd = c; cmd_valid = 1'b1;
    @(negedge uart_clk); cmd_valid = 1'b0;
    repeat (130) begin
      @(posedge uart_clk); #1;
      if (!tx) lows++;
      if (busy) busys++;
    end
    check("rsv_tx_quiet", lows, 0);
    check("rsv_busy_low", busys, 0);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, busys, strobes;
    reset = 1'b0; cmd = 3'd0; cmd_valid = 1'b0; rx = 1'b1; cts = 1'b0;
    repeat (3) @(posedge uart_clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {dump_valid, dump_done, err}, 3'b000);
    check("rst_dump", {dump_idx, dump_data}, 13'h0);
    @(negedge uart_clk); reset = 1'b1;
    repeat (4) @(negedge uart_clk);

    // continue with cts held 30 clocks past the stop bit
    send_cmd(3'd1, 1'b1, 30);
    wait_idle(20);
    // BREAK
    send_cmd(3'd0, 1'b1, 10);
    wait_idle(20);
    // step with sequential dump and an rx glitch inside the response window
    run_step(-1, 1'b1, 1'b1);
    // framing error on byte 5
    run_step(5, 1'b0, 1'b1);

    // reset in the middle of data bit 3 of an 'i' frame
    @(negedge uart_clk);
    cmd = 3'd2; cmd_valid = 1'b1;
    @(posedge uart_clk);
    @(negedge uart_clk); cmd_valid = 1'b0;
    repeat (55) @(posedge uart_clk);
    #1;
    check("pre_rst_bit3", tx, 1'b1);
    check("pre_rst_busy", busy, 1'b1);
    @(negedge uart_clk); reset = 1'b0;
    @(posedge uart_clk); #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", cmd_ready, 1'b0);
    check("midrst_strobes", {dump_valid, dump_done, err}, 3'b000);
    repeat (2) @(negedge uart_clk);
    reset = 1'b1;
    lows = 0; busys = 0; strobes = err_cnt + got_q.size();
    @(negedge uart_clk); rx = 1'b0;
    repeat (2) @(negedge uart_clk); rx = 1'b1;
    repeat (120) begin
      @(posedge uart_clk); #1;
      if (!tx) lows++;
      if (busy) busys++;
    end
    check("postrst_tx_quiet", lows, 0);
    check("postrst_busy", busys, 0);
    check("postrst_glitch", err_cnt + got_q.size(), strobes);
    run_reserved(3'd7);

    // random traffic
    for (int it = 0; it < 8; it++) begin
      logic [2:0] c;
      c = 3'($urandom_range(0, 7));
      if (c == 3'd5)
        run_step(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DUMP_LEN - 1)) : -1,
                 1'($urandom_range(0, 1)), 1'b0);
      else if (c >= 3'd6)
        run_reserved(c);
      else begin
        send_cmd(c, 1'($urandom_range(0, 1)), int'($urandom_range(0, 40)));
        wait_idle(40);
      end
    end

`ifdef DBG_HOST_TIMEOUT_EN
    begin
      int e0, n;
      send_cmd(3'd5, 1'b0, 0);
      e0 = err_cnt; n = 0;
      while (busy && n < STEP_TO * 12 + 200) begin
        @(posedge uart_clk); #1; n++;
      end
      check("to_err", err_cnt - e0, 1);
      check($sformatf("to_not_early n=%0d", n), (n >= STEP_TO * 12 - 4), 1'b1);
      check("to_idle", busy, 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
